// File: rtl/l2_reader_pkg.sv
// Shared constants, FSM state type and tap-pair table for the layer-2 window reader.
// L2_ZERO_PAD_EN selects same-padding (14x14 output grid) instead of valid padding (12x12).
package l2_reader_pkg;

    localparam int MAP_DIM    = 14;
    localparam int ROW_STRIDE = 56;
    localparam int COL_STRIDE = 2;
    localparam int K          = 3;
    localparam int NCH        = 8;
    localparam int DW         = 8;
    localparam int AW         = 10;
    localparam int TAPS       = K * K;
    localparam int PAIRS      = 5;

`ifdef L2_ZERO_PAD_EN
    localparam int OUT_DIM = MAP_DIM;
    localparam int PAD     = 1;
`else
    localparam int OUT_DIM = MAP_DIM - K + 1;
    localparam int PAD     = 0;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DRAIN   = 3'd2,
        PRESENT = 3'd3,
        FINISH  = 3'd4
    } state_t;

    // First tap issued on each read pair.
    function automatic logic [3:0] pair_tap1(input logic [2:0] pair);
        logic [3:0] tap;
        case (pair)
            3'd0:    tap = 4'd0;
            3'd1:    tap = 4'd2;
            3'd2:    tap = 4'd4;
            3'd3:    tap = 4'd6;
            3'd4:    tap = 4'd8;
            default: tap = 4'd0;
        endcase
        return tap;
    endfunction

    // Second tap issued on each read pair; the last pair repeats tap 8.
    function automatic logic [3:0] pair_tap2(input logic [2:0] pair);
        logic [3:0] tap;
        case (pair)
            3'd0:    tap = 4'd1;
            3'd1:    tap = 4'd3;
            3'd2:    tap = 4'd5;
            3'd3:    tap = 4'd7;
            3'd4:    tap = 4'd8;
            default: tap = 4'd0;
        endcase
        return tap;
    endfunction

endpackage

// File: rtl/l2_window_reader_if.sv
// Memory load port plus window stream between the layer-2 reader and its neighbours.
interface l2_window_reader_if;
    import l2_reader_pkg::*;

    logic                    load;
    logic [AW-1:0]           addr1;
    logic [AW-1:0]           addr2;
    logic [NCH*DW-1:0]       rd_data1;
    logic [NCH*DW-1:0]       rd_data2;
    logic                    win_valid;
    logic                    win_ready;
    logic [NCH*TAPS*DW-1:0]  win_data;
    logic [3:0]              win_row;
    logic [3:0]              win_col;

    modport master (
        output load, addr1, addr2, win_valid, win_data, win_row, win_col,
        input  rd_data1, rd_data2, win_ready
    );

    modport slave (
        input  load, addr1, addr2, win_valid, win_data, win_row, win_col,
        output rd_data1, rd_data2, win_ready
    );

endinterface

// File: rtl/l2_tap_addr_gen.sv
// Maps an output position and read-pair index to two pooled-map addresses and in-bounds flags.
// Honors L2_ZERO_PAD_EN through the package PAD offset; out-of-bounds taps drive address 0.
module l2_tap_addr_gen
    import l2_reader_pkg::*;
(
    input  logic [3:0]    orow,
    input  logic [3:0]    ocol,
    input  logic [2:0]    pair,
    output logic [AW-1:0] addr1,
    output logic [AW-1:0] addr2,
    output logic          in1,
    output logic          in2
);

    // Returns {in_bounds, address} for one tap of the window anchored at (row, col).
    function automatic logic [AW:0] tap_loc(input logic [3:0] row, input logic [3:0] col,
                                            input logic [3:0] tap);
        int          kr;
        int          kc;
        int          pr;
        int          pc;
        logic [AW:0] loc;
        kr = int'(tap) / K;
        kc = int'(tap) % K;
        pr = int'(row) + kr - PAD;
        pc = int'(col) + kc - PAD;
        if (pr >= 0 && pr < MAP_DIM && pc >= 0 && pc < MAP_DIM) begin
            loc = {1'b1, AW'(ROW_STRIDE * pr + COL_STRIDE * pc)};
        end else begin
            loc = {1'b0, {AW{1'b0}}};
        end
        return loc;
    endfunction

    logic [AW:0] loc1_s;
    logic [AW:0] loc2_s;

    // Resolve both taps of the requested pair.
    always_comb begin
        loc1_s = tap_loc(orow, ocol, pair_tap1(pair));
        loc2_s = tap_loc(orow, ocol, pair_tap2(pair));
        in1    = loc1_s[AW];
        in2    = loc2_s[AW];
        addr1  = loc1_s[AW-1:0];
        addr2  = loc2_s[AW-1:0];
    end

endmodule

// File: rtl/l2_window_reader.sv
// Layer-2 window reader: sweeps the pooled layer-1 maps and streams 8-channel 3x3 windows.
// Optional macro L2_ZERO_PAD_EN enables same-padding (196 windows, zero-filled border taps).
module l2_window_reader
    import l2_reader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    l2_window_reader_if.master bus
);

    localparam logic [3:0] LAST_POS  = 4'(OUT_DIM - 1);
    localparam logic [2:0] LAST_PAIR = 3'(PAIRS - 1);

    state_t                  state_r;
    logic [3:0]              orow_r, ocol_r;
    logic [2:0]              pair_r;
    logic                    load_r, in1_r, in2_r;
    logic [AW-1:0]           addr1_r, addr2_r;
    logic                    cap_en_r, cap_in1_r, cap_in2_r;
    logic [2:0]              cap_pair_r;
    logic [NCH*TAPS*DW-1:0]  win_data_r;
    logic                    win_valid_r, busy_r, done_r;

    logic [3:0]              nxt_row_s, nxt_col_s, gen_row_s, gen_col_s;
    logic [2:0]              gen_pair_s;
    logic [AW-1:0]           gen_addr1_s, gen_addr2_s;
    logic                    gen_in1_s, gen_in2_s, hs_s, last_pos_s;

    assign hs_s       = win_valid_r && bus.win_ready;
    assign last_pos_s = (orow_r == LAST_POS) && (ocol_r == LAST_POS);

    // Next raster position and the address-generator inputs for the pair issued next cycle.
    always_comb begin
        nxt_row_s  = orow_r;
        nxt_col_s  = ocol_r;
        gen_row_s  = orow_r;
        gen_col_s  = ocol_r;
        gen_pair_s = 3'd0;
        if (ocol_r == LAST_POS) begin
            nxt_row_s = orow_r + 4'd1;
            nxt_col_s = 4'd0;
        end else begin
            nxt_row_s = orow_r;
            nxt_col_s = ocol_r + 4'd1;
        end
        case (state_r)
            PRESENT: begin
                gen_row_s  = nxt_row_s;
                gen_col_s  = nxt_col_s;
                gen_pair_s = 3'd0;
            end
            FETCH:   gen_pair_s = pair_r + 3'd1;
            default: gen_pair_s = 3'd0;
        endcase
    end

    l2_tap_addr_gen u_addr_gen (
        .orow  (gen_row_s),
        .ocol  (gen_col_s),
        .pair  (gen_pair_s),
        .addr1 (gen_addr1_s),
        .addr2 (gen_addr2_s),
        .in1   (gen_in1_s),
        .in2   (gen_in2_s)
    );

    // Sweep FSM with registered load port, handshake and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            orow_r      <= 4'd0;
            ocol_r      <= 4'd0;
            pair_r      <= 3'd0;
            load_r      <= 1'b0;
            addr1_r     <= {AW{1'b0}};
            addr2_r     <= {AW{1'b0}};
            in1_r       <= 1'b0;
            in2_r       <= 1'b0;
            win_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= FETCH;
                        busy_r  <= 1'b1;
                        load_r  <= 1'b1;
                        pair_r  <= 3'd0;
                        addr1_r <= gen_addr1_s;
                        addr2_r <= gen_addr2_s;
                        in1_r   <= gen_in1_s;
                        in2_r   <= gen_in2_s;
                    end
                end
                FETCH: begin
                    if (pair_r == LAST_PAIR) begin
                        state_r <= DRAIN;
                        load_r  <= 1'b0;
                        addr1_r <= {AW{1'b0}};
                        addr2_r <= {AW{1'b0}};
                    end else begin
                        pair_r  <= pair_r + 3'd1;
                        addr1_r <= gen_addr1_s;
                        addr2_r <= gen_addr2_s;
                        in1_r   <= gen_in1_s;
                        in2_r   <= gen_in2_s;
                    end
                end
                DRAIN: begin
                    state_r     <= PRESENT;
                    win_valid_r <= 1'b1;
                end
                PRESENT: begin
                    if (hs_s) begin
                        win_valid_r <= 1'b0;
                        if (last_pos_s) begin
                            state_r <= FINISH;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            orow_r  <= 4'd0;
                            ocol_r  <= 4'd0;
                        end else begin
                            state_r <= FETCH;
                            orow_r  <= nxt_row_s;
                            ocol_r  <= nxt_col_s;
                            load_r  <= 1'b1;
                            pair_r  <= 3'd0;
                            addr1_r <= gen_addr1_s;
                            addr2_r <= gen_addr2_s;
                            in1_r   <= gen_in1_s;
                            in2_r   <= gen_in2_s;
                        end
                    end
                end
                FINISH: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    load_r      <= 1'b0;
                    win_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    // Read data lands one cycle after its load; the delayed pair index steers it into tap slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_en_r   <= 1'b0;
            cap_pair_r <= 3'd0;
            cap_in1_r  <= 1'b0;
            cap_in2_r  <= 1'b0;
            win_data_r <= {(NCH*TAPS*DW){1'b0}};
        end else begin
            cap_en_r   <= load_r;
            cap_pair_r <= pair_r;
            cap_in1_r  <= in1_r;
            cap_in2_r  <= in2_r;
            if (cap_en_r) begin
                for (int c = 0; c < NCH; c++) begin
                    win_data_r[(c*TAPS + int'(pair_tap1(cap_pair_r)))*DW +: DW] <=
                        cap_in1_r ? bus.rd_data1[c*DW +: DW] : {DW{1'b0}};
                    win_data_r[(c*TAPS + int'(pair_tap2(cap_pair_r)))*DW +: DW] <=
                        cap_in2_r ? bus.rd_data2[c*DW +: DW] : {DW{1'b0}};
                end
            end
        end
    end

    assign bus.load      = load_r;
    assign bus.addr1     = addr1_r;
    assign bus.addr2     = addr2_r;
    assign bus.win_valid = win_valid_r;
    assign bus.win_data  = win_data_r;
    assign bus.win_row   = orow_r;
    assign bus.win_col   = ocol_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_l2_window_reader.sv
// Self-checking bench for l2_window_reader: reference memory, per-cycle window/address model,
// and directed checks on timing, stalls, abort-by-reset and a full sweep.
module tb_l2_window_reader;
    import l2_reader_pkg::*;

`ifdef L2_ZERO_PAD_EN
    localparam int OD   = 14;
    localparam int PADV = 1;
`else
    localparam int OD   = 12;
    localparam int PADV = 0;
`endif
    localparam int NWIN = OD * OD;
    localparam int WW   = NCH * TAPS * DW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, done;

    l2_window_reader_if bus();

    l2_window_reader dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string nm, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic logic [7:0] mem_val(input int a, input int c);
        return 8'((a + 16 * c) % 128);
    endfunction

    // Address of tap t of window k in raster order, or -1 when it falls outside the map.
    function automatic int tap_addr(input int k, input int t);
        int pr;
        int pc;
        pr = k / OD + t / 3 - PADV;
        pc = k % OD + t % 3 - PADV;
        if (pr < 0 || pr > 13 || pc < 0 || pc > 13) return -1;
        return 56 * pr + 2 * pc;
    endfunction

    function automatic logic [WW-1:0] exp_window(input int k);
        logic [WW-1:0] w;
        int a;
        w = '0;
        for (int c = 0; c < NCH; c++)
            for (int t = 0; t < TAPS; t++) begin
                a = tap_addr(k, t);
                w[(c*TAPS+t)*8 +: 8] = (a < 0) ? 8'd0 : mem_val(a, c);
            end
        return w;
    endfunction

    function automatic int wb(input logic [WW-1:0] w, input int c, input int t);
        return int'(w[(c*TAPS+t)*8 +: 8]);
    endfunction

    // One-cycle registered read memory for both ports.
    always @(posedge clk) begin
        if (bus.load) begin
            for (int c = 0; c < NCH; c++) begin
                bus.rd_data1[c*8 +: 8] <= mem_val(int'(bus.addr1), c);
                bus.rd_data2[c*8 +: 8] <= mem_val(int'(bus.addr2), c);
            end
        end
    end

    int hs_n = 0, lc = 0, done_n = 0, ncyc = 0, done_cyc = 0, sweep_hs = 0;
    int last_a1 = -1, last_a2 = -1, last_row = -1, last_col = -1, first_row = -1, first_col = -1;
    logic [WW-1:0] first_win, last_win;

    // Per-cycle comparison of the DUT against the window/address model.
    always @(negedge clk) begin
        int p, t1, t2, e1, e2;
        logic [WW-1:0] ew;
        ncyc++;
        if (!rst) begin
            chk(!busy && !done && !bus.load && bus.addr1 == 0 && bus.addr2 == 0 && !bus.win_valid
                && bus.win_data == 0 && bus.win_row == 0 && bus.win_col == 0,
                "reset_outputs", {busy, done, bus.load, bus.win_valid}, 0);
            hs_n = 0;
            lc = 0;
        end else begin
            if (bus.load) begin
                chk(lc < 5 && !bus.win_valid && busy, "load_slot", lc, 4);
                p  = (lc > 4) ? 4 : lc;
                t1 = (p == 4) ? 8 : 2 * p;
                t2 = (p == 4) ? 8 : 2 * p + 1;
                e1 = tap_addr(hs_n, t1);
                e2 = tap_addr(hs_n, t2);
                if (e1 < 0) e1 = 0;
                if (e2 < 0) e2 = 0;
                chk(int'(bus.addr1) == e1, "addr1", bus.addr1, e1);
                chk(int'(bus.addr2) == e2, "addr2", bus.addr2, e2);
                last_a1 = int'(bus.addr1);
                last_a2 = int'(bus.addr2);
                lc++;
            end
            if (bus.win_valid) begin
                chk(lc == 5, "loads_before_window", lc, 5);
                chk(int'(bus.win_row) == hs_n / OD, "win_row", bus.win_row, hs_n / OD);
                chk(int'(bus.win_col) == hs_n % OD, "win_col", bus.win_col, hs_n % OD);
                ew = exp_window(hs_n);
                checks++;
                if (bus.win_data !== ew) begin
                    errors++;
                    $display("FAIL win_data k=%0d actual=%h required=%h", hs_n, bus.win_data, ew);
                end
                if (bus.win_ready) begin
                    if (hs_n == 0) begin
                        first_win = bus.win_data;
                        first_row = int'(bus.win_row);
                        first_col = int'(bus.win_col);
                    end
                    last_win = bus.win_data;
                    last_row = int'(bus.win_row);
                    last_col = int'(bus.win_col);
                    hs_n++;
                    lc = 0;
                end
            end
            if (done) begin
                done_n++;
                done_cyc = ncyc;
                chk(!busy && hs_n == NWIN, "done_state", hs_n, NWIN);
                sweep_hs = hs_n;
                hs_n = 0;
                lc = 0;
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout actual=%0d required=%0d", done_n, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int e_a1[5], e_a2[5], e_tap[9], ld[9], a1[9], a2[9], wv[9], bz[9];
        int hs_before, t0;
        logic [WW-1:0] snap;
        logic [3:0] snap_row, snap_col;
`ifdef L2_ZERO_PAD_EN
        e_a1  = '{0, 0, 0, 0, 58};
        e_a2  = '{0, 0, 2, 56, 58};
        e_tap = '{0, 0, 0, 0, 0, 2, 0, 56, 58};
`else
        e_a1  = '{0, 4, 58, 112, 116};
        e_a2  = '{2, 56, 60, 114, 116};
        e_tap = '{0, 2, 4, 56, 58, 60, 112, 114, 116};
`endif
        bus.win_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 chk(!busy && !bus.win_valid && !bus.load, "idle_after_reset", busy, 0);

        // First window timing and addresses with the consumer stalled.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            ld[i] = int'(bus.load); a1[i] = int'(bus.addr1); a2[i] = int'(bus.addr2);
            wv[i] = int'(bus.win_valid); bz[i] = int'(busy);
        end
        for (int i = 1; i <= 5; i++) begin
            chk(ld[i] == 1, "load_T1_T5", ld[i], 1);
            chk(a1[i] == e_a1[i-1], "lit_addr1", a1[i], e_a1[i-1]);
            chk(a2[i] == e_a2[i-1], "lit_addr2", a2[i], e_a2[i-1]);
        end
        chk(ld[6] == 0, "drain_no_load", ld[6], 0);
        chk(wv[6] == 0 && wv[7] == 1, "first_valid_T7", wv[7], 1);
        chk(bz[1] == 1, "busy_after_start", bz[1], 1);
        snap = bus.win_data; snap_row = bus.win_row; snap_col = bus.win_col;
        for (int t = 0; t < 9; t++)
            chk(wb(snap, 0, t) == e_tap[t] % 128, "lit_ch0_tap", wb(snap, 0, t), e_tap[t] % 128);

        // Stall: window must hold, no loads, a stray start is ignored.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk(!bus.load && bus.win_valid && bus.win_data == snap && bus.win_row == snap_row
                && bus.win_col == snap_col, "stall_hold", bus.load, 0);
            if (i == 3) #1 start = 1'b1;
            if (i == 4) #1 start = 1'b0;
        end
        hs_before = hs_n;
        @(posedge clk); #1 bus.win_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 bus.win_ready = 1'b0;
        @(negedge clk);
        #1 chk(hs_n == hs_before + 1, "single_handshake", hs_n, hs_before + 1);
        chk(!bus.win_valid && bus.load, "refetch_after_accept", bus.load, 1);

        // Abort in FETCH.
        rst = 1'b0;
        #1 chk(!busy && !done && !bus.load && !bus.win_valid && bus.addr1 == 0 && bus.addr2 == 0
               && bus.win_data == 0, "abort_zero", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk(!busy && !bus.load && done_n == 0, "abort_idle_no_done", done_n, 0);

        // Full sweep with the consumer always ready.
        bus.win_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk); #1 t0 = ncyc;
        @(posedge clk); #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 2000 && done_n == 0; i++) @(negedge clk);
        #1 chk(done_n == 1, "done_seen", done_n, 1);
        chk(sweep_hs == NWIN, "sweep_windows", sweep_hs, NWIN);
        chk(done_cyc - t0 == 7 * NWIN + 1, "done_latency", done_cyc - t0, 7 * NWIN + 1);
        chk(first_row == 0 && first_col == 0, "restart_origin", first_row * 16 + first_col, 0);
        chk(last_row == OD - 1 && last_col == OD - 1, "last_position", last_row * 16 + last_col,
            (OD - 1) * 17);
        for (int t = 0; t < 9; t++)
            chk(wb(first_win, 0, t) == e_tap[t] % 128, "restart_ch0_tap", wb(first_win, 0, t),
                e_tap[t] % 128);
`ifdef L2_ZERO_PAD_EN
        chk(last_a1 == 0 && last_a2 == 0, "last_pair_oob", last_a1, 0);
        chk(wb(first_win, 1, 0) == 0 && wb(first_win, 1, 1) == 0 && wb(first_win, 1, 2) == 0
            && wb(first_win, 1, 3) == 0 && wb(first_win, 1, 6) == 0, "pad_first_zero", 1, 0);
        chk(wb(first_win, 1, 4) == 16, "pad_first_tap4", wb(first_win, 1, 4), 16);
        chk(wb(first_win, 1, 8) == 74, "pad_first_tap8", wb(first_win, 1, 8), 74);
        chk(wb(last_win, 1, 2) == 0 && wb(last_win, 1, 5) == 0 && wb(last_win, 1, 6) == 0
            && wb(last_win, 1, 7) == 0 && wb(last_win, 1, 8) == 0, "pad_last_zero", 1, 0);
        chk(wb(last_win, 1, 4) == 2, "pad_last_tap4", wb(last_win, 1, 4), 2);
`else
        chk(last_a1 == 754 && last_a2 == 754, "last_pair_754", last_a1, 754);
        chk(wb(last_win, 0, 0) == 638 % 128, "last_base_tap", wb(last_win, 0, 0), 638 % 128);
`endif
        repeat (10) @(negedge clk);
        #1 chk(done_n == 1 && !busy && !bus.load && !bus.win_valid, "idle_after_done", done_n, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
